// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : opcodes, instruction fields, datapath sizes, FSM encoding | rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int DATA_W  = 8;
   localparam int NREGS   = 4;
   localparam int REG_AW  = 2;
   localparam int INSTR_W = 16;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 8;
   localparam int RS2_MSB = 7;
   localparam int RS2_LSB = 6;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_INC = 4'b0010;
   localparam logic [3:0] OP_DEC = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   function automatic logic [3:0] f_opcode(input logic [INSTR_W-1:0] i);
      return i[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] i);
      return i[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [REG_AW-1:0] f_rs1(input logic [INSTR_W-1:0] i);
      return i[RS1_MSB:RS1_LSB];
   endfunction

   function automatic logic [REG_AW-1:0] f_rs2(input logic [INSTR_W-1:0] i);
      return i[RS2_MSB:RS2_LSB];
   endfunction

   function automatic logic [DATA_W-1:0] f_imm(input logic [INSTR_W-1:0] i);
      return i[IMM_MSB:IMM_LSB];
   endfunction

endpackage

`default_nettype wire

// File: rtl/exec_ctrl_if.sv
// ============================================================================
// exec_ctrl_if : instruction, ALU, write-back and debug signals | rev 1.0
// ============================================================================
`default_nettype none

interface exec_ctrl_if;
   import cpu_pkg::*;

   logic                 instr_valid;
   logic [INSTR_W-1:0]   instr;
   logic                 instr_ready;
   logic [3:0]           alu_op;
   logic [DATA_W-1:0]    alu_a;
   logic [DATA_W-1:0]    alu_b;
   logic [DATA_W-1:0]    alu_result;
   logic                 alu_zero;
   logic                 wb_valid;
   logic [REG_AW-1:0]    wb_addr;
   logic [DATA_W-1:0]    wb_data;
   logic                 zero_flag;
   logic [REG_AW-1:0]    dbg_addr;
   logic [DATA_W-1:0]    dbg_data;

   modport slave (
      input  instr_valid, instr, alu_result, alu_zero, dbg_addr,
      output instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data,
             zero_flag, dbg_data
   );

   modport master (
      output instr_valid, instr, alu_result, alu_zero, dbg_addr,
      input  instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data,
             zero_flag, dbg_data
   );

endinterface

`default_nettype wire

// File: rtl/exec_regfile.sv
// ============================================================================
// exec_regfile : 4x8 register file, 3 async read ports, 1 sync write | rev 1.0
// ============================================================================
`default_nettype none

module exec_regfile
   import cpu_pkg::*;
(
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic [REG_AW-1:0] i_rs1,
   input  wire logic [REG_AW-1:0] i_rs2,
   input  wire logic [REG_AW-1:0] i_dbg,
   output logic      [DATA_W-1:0] o_rd1,
   output logic      [DATA_W-1:0] o_rd2,
   output logic      [DATA_W-1:0] o_dbg,
   input  wire logic              i_we,
   input  wire logic [REG_AW-1:0] i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] r_regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Reads bypass nothing: a write becomes visible the cycle after it lands.
   assign o_rd1 = r_regs[i_rs1];
   assign o_rd2 = r_regs[i_rs2];
   assign o_dbg = r_regs[i_dbg];

endmodule

`default_nettype wire

// File: rtl/exec_ctrl.sv
// ============================================================================
// exec_ctrl : 3-state instruction sequencer with regfile and result latch | rev 1.0
// ============================================================================
`default_nettype none

module exec_ctrl
   import cpu_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  rst,
   exec_ctrl_if.slave bus
);

   state_t             r_state;
   state_t             w_next;
   logic [INSTR_W-1:0] r_instr;
   logic [DATA_W-1:0]  r_result;
   logic               r_zero;

   logic               w_accept;
   logic               w_is_cmp;
   logic               w_we;
   logic [3:0]         w_op;
   logic [REG_AW-1:0]  w_rd;
   logic [DATA_W-1:0]  w_rd1;
   logic [DATA_W-1:0]  w_rd2;

   assign w_op     = f_opcode(r_instr);
   assign w_rd     = f_rd(r_instr);
   assign w_is_cmp = (w_op == OP_CMP);
   assign w_accept = bus.instr_valid && (r_state == ST_IDLE);

   exec_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_rs1   (f_rs1(r_instr)),
      .i_rs2   (f_rs2(r_instr)),
      .i_dbg   (bus.dbg_addr),
      .o_rd1   (w_rd1),
      .o_rd2   (w_rd2),
      .o_dbg   (bus.dbg_data),
      .i_we    (w_we),
      .i_waddr (w_rd),
      .i_wdata (r_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      bus.instr_ready = 1'b0;
      bus.alu_op      = '0;
      bus.alu_a       = '0;
      bus.alu_b       = '0;
      w_we            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) begin
               w_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            bus.alu_op = w_op;
            bus.alu_a  = w_rd1;
            bus.alu_b  = w_rd2;
            w_next     = ST_WRITE;
         end
         ST_WRITE: begin
            w_we   = !w_is_cmp;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Result and flag are captured on the EXEC->WRITE edge; an async reset
   // in EXEC or WRITE therefore discards the instruction before any write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr  <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_instr <= bus.instr;
         end
         if (r_state == ST_EXEC) begin
            r_result <= (w_op == OP_LDI) ? f_imm(r_instr) : bus.alu_result;
            if (w_is_cmp) begin
               r_zero <= bus.alu_zero;
            end
         end
      end
   end

   assign bus.wb_valid  = w_we;
   assign bus.wb_addr   = w_we ? w_rd : '0;
   assign bus.wb_data   = w_we ? r_result : '0;
   assign bus.zero_flag = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_exec_ctrl.sv
// ============================================================================
// tb_exec_ctrl : directed self-checking bench for exec_ctrl | rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_ctrl;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   int   n_fail;
   int   n_rdy;
   int   n_wb;

   exec_ctrl_if bus ();

   exec_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; undefined opcodes fall back to ADD.
   always_comb begin
      case (bus.alu_op)
         4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
         4'b0010: bus.alu_result = bus.alu_a + 8'd1;
         4'b0011: bus.alu_result = bus.alu_a - 8'd1;
         4'b0100: bus.alu_result = bus.alu_a & bus.alu_b;
         4'b0101: bus.alu_result = bus.alu_a | bus.alu_b;
         4'b0110: bus.alu_result = bus.alu_a ^ bus.alu_b;
         4'b0111: bus.alu_result = ~bus.alu_a;
         4'b1000: bus.alu_result = bus.alu_a << 1;
         4'b1001: bus.alu_result = bus.alu_a - bus.alu_b;
         default: bus.alu_result = bus.alu_a + bus.alu_b;
      endcase
      bus.alu_zero = (bus.alu_result == 8'h00);
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
      return {op, rd, rs1, rs2, 6'b000000};
   endfunction

   function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
      return {4'hF, rd, 2'b00, imm};
   endfunction

   // Offers one instruction and returns one cycle after acceptance (EXEC).
   task automatic accept(input logic [15:0] ins);
      int n = 0;
      while (bus.instr_ready !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk("accept_ready", {15'd0, bus.instr_ready}, 16'h0001);
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      step();
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
   endtask

   task automatic load(input logic [1:0] rd, input logic [7:0] imm);
      accept(ldi(rd, imm));
      step();
      chk("ldi_wb_data", {8'd0, bus.wb_data}, {8'd0, imm});
      step();
   endtask

   initial begin
      n_total         = 0;
      n_pass          = 0;
      n_fail          = 0;
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      bus.dbg_addr    = 2'd0;
      step();
      step();
      rst = 1'b0;
      step();

      chk("rst_ready",  {15'd0, bus.instr_ready}, 16'h0001);
      chk("rst_wbv",    {15'd0, bus.wb_valid},    16'h0000);
      chk("rst_wba",    {14'd0, bus.wb_addr},     16'h0000);
      chk("rst_wbd",    {8'd0,  bus.wb_data},     16'h0000);
      chk("rst_aluop",  {12'd0, bus.alu_op},      16'h0000);
      chk("rst_alua",   {8'd0,  bus.alu_a},       16'h0000);
      chk("rst_alub",   {8'd0,  bus.alu_b},       16'h0000);
      chk("rst_zero",   {15'd0, bus.zero_flag},   16'h0000);
      for (int i = 0; i < 4; i++) begin
         bus.dbg_addr = 2'(i);
         #1;
         chk("rst_reg", {8'd0, bus.dbg_data}, 16'h0000);
      end

      // LDI R1,5 ; LDI R2,3 ; ADD R3,R1,R2
      accept(ldi(2'd1, 8'h05));
      chk("ldi_exec_op", {12'd0, bus.alu_op}, 16'h000F);
      step();
      chk("ldi1_wbv", {15'd0, bus.wb_valid}, 16'h0001);
      chk("ldi1_wba", {14'd0, bus.wb_addr},  16'h0001);
      chk("ldi1_wbd", {8'd0,  bus.wb_data},  16'h0005);
      step();
      chk("idle_wbv", {15'd0, bus.wb_valid}, 16'h0000);
      chk("idle_aluop", {12'd0, bus.alu_op}, 16'h0000);
      accept(ldi(2'd2, 8'h03));
      step();
      chk("ldi2_wba", {14'd0, bus.wb_addr}, 16'h0002);
      chk("ldi2_wbd", {8'd0,  bus.wb_data}, 16'h0003);
      step();
      accept(enc(4'h0, 2'd3, 2'd1, 2'd2));
      chk("add_ready_exec", {15'd0, bus.instr_ready}, 16'h0000);
      chk("add_alua", {8'd0, bus.alu_a}, 16'h0005);
      chk("add_alub", {8'd0, bus.alu_b}, 16'h0003);
      step();
      chk("add_wbv", {15'd0, bus.wb_valid}, 16'h0001);
      chk("add_wba", {14'd0, bus.wb_addr},  16'h0003);
      chk("add_wbd", {8'd0,  bus.wb_data},  16'h0008);
      bus.dbg_addr = 2'd3;
      #1;
      chk("add_dbg_old", {8'd0, bus.dbg_data}, 16'h0000);
      step();
      chk("add_dbg_new", {8'd0, bus.dbg_data}, 16'h0008);

      // INC R1 from 0xFF wraps to 0; zero_flag stays 0
      load(2'd1, 8'hFF);
      accept(enc(4'h2, 2'd1, 2'd1, 2'd0));
      chk("inc_alua", {8'd0, bus.alu_a}, 16'h00FF);
      chk("inc_aluop", {12'd0, bus.alu_op}, 16'h0002);
      step();
      chk("inc_wba", {14'd0, bus.wb_addr}, 16'h0001);
      chk("inc_wbd", {8'd0,  bus.wb_data}, 16'h0000);
      step();
      chk("inc_zero", {15'd0, bus.zero_flag}, 16'h0000);

      // CMP equal then unequal
      load(2'd1, 8'h05);
      load(2'd2, 8'h05);
      accept(enc(4'h9, 2'd0, 2'd1, 2'd2));
      step();
      chk("cmp_wbv", {15'd0, bus.wb_valid}, 16'h0000);
      chk("cmp_zero_eq", {15'd0, bus.zero_flag}, 16'h0001);
      step();
      load(2'd2, 8'h06);
      chk("ldi_keeps_zero", {15'd0, bus.zero_flag}, 16'h0001);
      accept(enc(4'h9, 2'd0, 2'd1, 2'd2));
      step();
      chk("cmp2_wbv", {15'd0, bus.wb_valid}, 16'h0000);
      chk("cmp_zero_ne", {15'd0, bus.zero_flag}, 16'h0000);
      step();
      bus.dbg_addr = 2'd0;
      #1;
      chk("cmp_no_write_r0", {8'd0, bus.dbg_data}, 16'h0000);

      // Opcode 1100 defaults to ADD; rd == rs1 reads the old value
      load(2'd1, 8'h10);
      load(2'd2, 8'h20);
      accept(enc(4'hC, 2'd1, 2'd1, 2'd2));
      chk("op12_alua", {8'd0, bus.alu_a}, 16'h0010);
      step();
      chk("op12_wba", {14'd0, bus.wb_addr}, 16'h0001);
      chk("op12_wbd", {8'd0,  bus.wb_data}, 16'h0030);
      bus.dbg_addr = 2'd1;
      #1;
      chk("op12_dbg_old", {8'd0, bus.dbg_data}, 16'h0010);
      step();
      chk("op12_dbg_new", {8'd0, bus.dbg_data}, 16'h0030);

      // Continuous instr_valid: INC R0 accepted once per three cycles
      n_rdy = 0;
      n_wb  = 0;
      bus.instr_valid = 1'b1;
      bus.instr       = enc(4'h2, 2'd0, 2'd0, 2'd0);
      for (int i = 0; i < 9; i++) begin
         if (bus.instr_ready === 1'b1) n_rdy++;
         step();
         if (bus.wb_valid === 1'b1) n_wb++;
      end
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      chk("stream_ready", 16'(n_rdy), 16'd3);
      chk("stream_wb",    16'(n_wb),  16'd3);
      bus.dbg_addr = 2'd0;
      #1;
      chk("stream_r0", {8'd0, bus.dbg_data}, 16'h0003);

      // Reset during EXEC aborts ADD R3
      accept(enc(4'h0, 2'd3, 2'd1, 2'd2));
      rst = 1'b1;
      #1;
      chk("abort_ready", {15'd0, bus.instr_ready}, 16'h0001);
      chk("abort_wbv",   {15'd0, bus.wb_valid},    16'h0000);
      step();
      rst = 1'b0;
      #1;
      chk("abort_wbv2", {15'd0, bus.wb_valid}, 16'h0000);
      chk("abort_ready2", {15'd0, bus.instr_ready}, 16'h0001);
      for (int i = 0; i < 4; i++) begin
         bus.dbg_addr = 2'(i);
         #1;
         chk("abort_reg", {8'd0, bus.dbg_data}, 16'h0000);
      end
      step();
      chk("abort_wbv3", {15'd0, bus.wb_valid}, 16'h0000);
      chk("abort_ready3", {15'd0, bus.instr_ready}, 16'h0001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr  input  16  [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (LDI only).
REQ-006 instr_ready  output  1  block accepts an instruction this cycle.
REQ-007 alu_op  output  4  opcode to the ALU.
REQ-008 alu_a  output  8  ALU operand1 = R[rs1].
REQ-009 alu_b  output  8  ALU operand2 = R[rs2].
REQ-010 alu_result  input  8  combinational ALU result.
REQ-011 alu_zero  input  1  ALU compare flag.
REQ-012 wb_valid  output  1  one-cycle pulse: register write this cycle.
REQ-013 wb_addr  output  2  destination register of the write.
REQ-014 wb_data  output  8  data written.
REQ-015 zero_flag  output  1  registered result of the last compare.
REQ-016 dbg_addr  input  2  debug read index; dbg_data  output  8  combinational R[dbg_addr].

Function
REQ-017 FSM SHALL have states IDLE, EXEC, WRITE; IDLE->EXEC on instr_valid&&instr_ready; EXEC->WRITE always; WRITE->IDLE always.
REQ-018 instr_ready SHALL be 1 only in IDLE; instr is latched on the accepting edge; instr_valid outside IDLE is ignored.
REQ-019 In EXEC: alu_op = latched opcode, alu_a = R[rs1], alu_b = R[rs2]; outside EXEC all three SHALL be 0.
REQ-020 On the EXEC->WRITE edge SHALL capture alu_result into a result register; for opcode 1111 (LDI) SHALL capture imm instead, ALU ignored.
REQ-021 Opcodes 0000-1000 and 1010-1110 SHALL write back the captured ALU result (1010-1110 yield ALU default ADD).
REQ-022 Opcode 1001 (CMP) SHALL update zero_flag from alu_zero on the EXEC->WRITE edge and SHALL NOT write a register (wb_valid stays 0).
REQ-023 Non-CMP opcodes SHALL leave zero_flag unchanged.
REQ-024 In WRITE (non-CMP) wb_valid=1, wb_addr=rd, wb_data=result; R[rd] updated on that edge.
REQ-025 Latency: accept edge to wb_valid = 2 cycles; throughput one instruction per 3 cycles.
REQ-026 rd equal to rs1/rs2 SHALL use old operand values (read in EXEC, write in WRITE).
REQ-027 dbg_data in the WRITE cycle SHALL show the old R[rd]; new value visible from the next cycle.
REQ-028 Arithmetic wraps modulo 256 (ALU behaviour); block adds no carry/overflow state.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, R[0..3]=0, result=0, zero_flag=0, latched instr=0.
REQ-030 Reset values: instr_ready=1 after release, wb_valid=0, wb_addr=0, wb_data=0, alu_op=0, alu_a=0, alu_b=0.
REQ-031 rst asserted in EXEC or WRITE SHALL abort the instruction with no register write and no wb_valid pulse.

Structure
REQ-032 Shared package cpu_pkg SHALL hold opcode constants (OP_ADD..OP_CMP, OP_LDI=1111), instr field positions, data width 8, register count 4, and the FSM state encoding.
REQ-033 Register file SHALL be sub-module exec_regfile: 4x8, three combinational read ports (rs1, rs2, dbg), one synchronous write port, async reset to 0.
REQ-034 exec_ctrl SHALL instantiate exec_regfile and contain the FSM, instr latch, result register and zero_flag.

Verification
REQ-035 LDI R1,0x05; LDI R2,0x03; ADD R3,R1,R2 -> wb pulses (1,05),(2,03),(3,08); dbg R3=0x08.
REQ-036 R1=0xFF; INC R1 (0010, rd=1, rs1=1) -> alu_a=0xFF in EXEC, wb (1,00), zero_flag unchanged.
REQ-037 R1=R2=0x05; CMP R1,R2 -> zero_flag=1, no wb_valid; then R2=0x06, CMP -> zero_flag=0.
REQ-038 instr_valid held high continuously -> instr_ready high one cycle in three; each instruction accepted exactly once.
REQ-039 rst asserted during EXEC of ADD R3 -> no wb_valid, all registers 0, state IDLE, instr_ready=1 after release.
REQ-040 Opcode 1100 with R1=0x10, R2=0x20 -> wb data 0x30; dbg read of rd during WRITE returns old value.
